// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a first-word-fall-through FIFO, 16x oversampled baud timing.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DVSR       = 163,
  parameter int STOP_TICKS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_empty,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int BAUD_W   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int TICK_MAX = (STOP_TICKS > 16) ? STOP_TICKS : 16;
  localparam int TICK_W   = $clog2(TICK_MAX);
  localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST      = BAUD_W'(DVSR - 1);
  localparam logic [TICK_W-1:0] BIT_TICK_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0] STOP_TICK_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  tx_reg;
  logic                  done_reg;
  logic                  baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg;
`endif

  // The divider only runs inside a frame, so every frame starts phase-aligned to the pop.
  assign baud_tick  = (state != IDLE) && (baud_cnt == BAUD_LAST);
  assign shift_next = shift_reg >> 1;

  assign tx_rd        = (state == IDLE) & ~tx_empty & ~reset;
  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;

      if (state == IDLE || baud_tick)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      // tx is driven from the transition that enters each bit, keeping the pin glitch-free.
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (tx_rd) begin
            shift_reg  <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^tx_data;
`endif
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            tx_reg     <= 1'b0;
            state      <= START;
          end
        end

        START: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              tx_reg   <= shift_reg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx_reg <= parity_reg;
                state  <= PARITY;
`else
                tx_reg <= 1'b1;
                state  <= STOP;
`endif
              end else begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + 1'b1;
                tx_reg    <= shift_next[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_TICK_LAST) begin
              tick_cnt <= '0;
              tx_reg   <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == STOP_TICK_LAST) begin
              tick_cnt <= '0;
              tx_reg   <= 1'b1;
              done_reg <= 1'b1;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx_reg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of frames with hand-written line bit patterns,
// plus idle, reset-mid-frame and long-stop sequences.
module tb_uart_tx_fifo;

  localparam int DVSR_TB = 4;
  localparam int BIT_CYC = 16 * DVSR_TB;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_SEGS = 1;
`else
  localparam int PAR_SEGS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tx_empty, tx_empty2;
  logic [7:0] tx_data, tx_data2;
  logic       tx_rd, tx, tx_busy, tx_done_tick;
  logic       tx_rd2, tx2, tx_busy2, tx_done_tick2;

  uart_tx_fifo #(.DATA_WIDTH(8), .DVSR(DVSR_TB), .STOP_TICKS(16)) u_dut (
    .clk(clk), .reset(reset), .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_rd(tx_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  uart_tx_fifo #(.DATA_WIDTH(8), .DVSR(DVSR_TB), .STOP_TICKS(32)) u_dut2 (
    .clk(clk), .reset(reset), .tx_empty(tx_empty2), .tx_data(tx_data2),
    .tx_rd(tx_rd2), .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2)
  );

  typedef struct {
    bit         first;
    int         grp_len;
    bit         sel;
    logic [7:0] data;
    logic [7:0] line_bits;
    logic       par;
  } frame_vec_t;

  logic [7:0] fifo1[$];
  logic [7:0] fifo2[$];
  int pops1, pops2;
  int total, bad;
  logic [1:0] smp_tx, smp_busy, smp_done, smp_rd;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifos();
    tx_empty  = (fifo1.size() == 0);
    tx_data   = tx_empty ? 8'h00 : fifo1[0];
    tx_empty2 = (fifo2.size() == 0);
    tx_data2  = tx_empty2 ? 8'h00 : fifo2[0];
  endtask

  // Sample both DUTs mid-cycle, then retire any popped word just after the edge.
  task automatic cycle();
    logic rd1, rd2;
    @(negedge clk);
    smp_tx   = {tx2, tx};
    smp_busy = {tx_busy2, tx_busy};
    smp_done = {tx_done_tick2, tx_done_tick};
    smp_rd   = {tx_rd2, tx_rd};
    rd1 = tx_rd;
    rd2 = tx_rd2;
    @(posedge clk);
    #1;
    if (rd1 && fifo1.size() > 0) begin void'(fifo1.pop_front()); pops1++; end
    if (rd2 && fifo2.size() > 0) begin void'(fifo2.pop_front()); pops2++; end
    drive_fifos();
  endtask

  task automatic applyStimulus(input bit sel, input logic [7:0] data);
    if (sel) fifo2.push_back(data); else fifo1.push_back(data);
    drive_fifos();
  endtask

  task automatic run_frame(input string tag, input bit sel, input logic [7:0] data,
                           input logic [7:0] bits, input logic par, input int stop_cyc,
                           input int exp_wait);
    int waited, frame_len, seg;
    int err_start, err_par, err_stop, err_busy, err_done, err_rd;
    int err_bit[8];
    logic exp_tx;
    logic [7:0] dec;
    waited = 0;
    err_start = 0; err_par = 0; err_stop = 0; err_busy = 0; err_done = 0; err_rd = 0;
    for (int k = 0; k < 8; k++) err_bit[k] = 0;
    dec = 8'h00;
    do begin
      cycle();
      waited++;
    end while (smp_tx[sel] !== 1'b0 && waited < 3000);
    if (smp_tx[sel] !== 1'b0) begin
      checkOutput({tag, " start timeout"}, 32'(smp_tx[sel]), 32'd0);
      return;
    end
    if (exp_wait > 0) checkOutput({tag, " gap"}, waited, exp_wait);
    frame_len = BIT_CYC * (9 + PAR_SEGS) + stop_cyc;
    for (int s = 0; s <= frame_len; s++) begin
      if (s > 0) cycle();
      seg = s / BIT_CYC;
      if (s == frame_len)                    exp_tx = 1'b1;
      else if (seg == 0)                     exp_tx = 1'b0;
      else if (seg <= 8)                     exp_tx = bits[8 - seg];
      else if (PAR_SEGS == 1 && seg == 9)    exp_tx = par;
      else                                   exp_tx = 1'b1;
      if (smp_tx[sel] !== exp_tx) begin
        if (seg == 0 && s < frame_len)                      err_start++;
        else if (seg <= 8 && s < frame_len)                 err_bit[seg - 1]++;
        else if (PAR_SEGS == 1 && seg == 9 && s < frame_len) err_par++;
        else                                                err_stop++;
      end
      if (seg >= 1 && seg <= 8 && (s % BIT_CYC) == BIT_CYC / 2) dec[seg - 1] = smp_tx[sel];
      if (smp_busy[sel] !== (s < frame_len)) err_busy++;
      if (smp_done[sel] !== (s == frame_len)) err_done++;
      if (s < frame_len && smp_rd[sel] !== 1'b0) err_rd++;
    end
    checkOutput({tag, " start bit bad cycles"}, err_start, 0);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("%s data bit %0d bad cycles", tag, k), err_bit[k], 0);
`ifdef UART_TX_PARITY_EN
    checkOutput({tag, " parity bad cycles"}, err_par, 0);
`endif
    checkOutput({tag, " stop bad cycles"}, err_stop, 0);
    checkOutput({tag, " busy bad cycles"}, err_busy, 0);
    checkOutput({tag, " done bad cycles"}, err_done, 0);
    checkOutput({tag, " rd in frame"}, err_rd, 0);
    checkOutput({tag, " decoded"}, 32'(dec), 32'(data));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    frame_vec_t vecs[7];
    int base, grp_len, err_tx, err_rd, err_busy, waited;

    vecs[0] = '{first: 1'b1, grp_len: 1, sel: 1'b0, data: 8'hA5, line_bits: 8'b10100101, par: 1'b0};
    vecs[1] = '{first: 1'b1, grp_len: 3, sel: 1'b0, data: 8'h00, line_bits: 8'b00000000, par: 1'b0};
    vecs[2] = '{first: 1'b0, grp_len: 0, sel: 1'b0, data: 8'hFF, line_bits: 8'b11111111, par: 1'b0};
    vecs[3] = '{first: 1'b0, grp_len: 0, sel: 1'b0, data: 8'h3C, line_bits: 8'b00111100, par: 1'b0};
    vecs[4] = '{first: 1'b1, grp_len: 2, sel: 1'b0, data: 8'h07, line_bits: 8'b11100000, par: 1'b1};
    vecs[5] = '{first: 1'b0, grp_len: 0, sel: 1'b0, data: 8'h03, line_bits: 8'b11000000, par: 1'b0};
    vecs[6] = '{first: 1'b1, grp_len: 1, sel: 1'b1, data: 8'h55, line_bits: 8'b10101010, par: 1'b0};

    total = 0; bad = 0; pops1 = 0; pops2 = 0;
    reset = 1'b1;
    drive_fifos();
    cycle();
    cycle();
    checkOutput("reset tx", 32'(smp_tx), 32'h3);
    checkOutput("reset busy", 32'(smp_busy), 32'h0);
    checkOutput("reset done", 32'(smp_done), 32'h0);
    checkOutput("reset rd", 32'(smp_rd), 32'h0);

    reset = 1'b0;
    err_tx = 0; err_rd = 0; err_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (smp_tx !== 2'b11) err_tx++;
      if (smp_rd !== 2'b00) err_rd++;
      if (smp_busy !== 2'b00) err_busy++;
    end
    checkOutput("idle tx low cycles", err_tx, 0);
    checkOutput("idle rd cycles", err_rd, 0);
    checkOutput("idle busy cycles", err_busy, 0);

    base = 0; grp_len = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].first) begin
        grp_len = vecs[i].grp_len;
        base = vecs[i].sel ? pops2 : pops1;
        for (int j = 0; j < grp_len; j++) applyStimulus(vecs[i + j].sel, vecs[i + j].data);
      end
      run_frame($sformatf("frame %0d (%02h)", i, vecs[i].data), vecs[i].sel, vecs[i].data,
                vecs[i].line_bits, vecs[i].par, vecs[i].sel ? 32 * DVSR_TB : 16 * DVSR_TB,
                vecs[i].first ? -1 : 1);
      if (i == 6 || vecs[i + 1].first)
        checkOutput($sformatf("group ending %0d pops", i),
                    (vecs[i].sel ? pops2 : pops1) - base, grp_len);
    end

    // Reset asserted in the middle of data bit 3 of 0xF0.
    base = pops1;
    applyStimulus(1'b0, 8'hF0);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (smp_tx[0] !== 1'b0 && waited < 3000);
    checkOutput("F0 start seen", 32'(smp_tx[0]), 32'd0);
    for (int i = 0; i < 4 * BIT_CYC + BIT_CYC / 2 - 1; i++) cycle();
    checkOutput("F0 bit3 before reset", 32'(smp_tx[0]), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid-frame reset tx", 32'(tx), 32'd1);
    checkOutput("mid-frame reset busy", 32'(tx_busy), 32'd0);
    checkOutput("mid-frame reset rd", 32'(tx_rd), 32'd0);
    checkOutput("F0 pops", pops1 - base, 1);
    applyStimulus(1'b0, 8'h12);
    err_rd = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (smp_rd[0] !== 1'b0) err_rd++;
    end
    checkOutput("rd held in reset", err_rd, 0);
    reset = 1'b0;
    base = pops1;
    run_frame("post-reset (12)", 1'b0, 8'h12, 8'b01001000, 1'b0, 16 * DVSR_TB, -1);
    checkOutput("post-reset pops", pops1 - base, 1);
    checkOutput("post-reset fifo left", fifo1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
